// File: rtl/dvi_iic_responder.sv
// I2C target modelling the DVI encoder configuration port: oversampled SCL/SDA,
// 256-entry register file with auto-incrementing pointer, write reporting.
module dvi_iic_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h76,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] REG_RESET  = 8'h00
) (
  input  logic       pixel_clk,
  input  logic       gpuclk_rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull_low,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy,
  output logic [7:0] nack_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEVADDR, S_ACK, S_IGNORE, S_PTR, S_WDATA, S_RDATA, S_RACK
  } state_t;

  state_t state, state_next, ack_next;

  logic [1:0]            scl_sync, sda_sync;
  logic [FILTER_LEN-1:0] scl_hist, sda_hist;
  logic                  scl_f, sda_f, scl_q, sda_q;
  logic                  scl_rise, scl_fall, start, stop;

  logic [7:0] regs [256];
  logic [7:0] ptr, shreg, rx_byte;
  logic [2:0] bit_cnt;
  logic       phase;  // ACK: 0 = waiting to drive, 1 = driving. RACK: 1 = master ACKed.

  // Synchronize, then only accept a level once it has been stable FILTER_LEN samples.
  always_ff @(posedge pixel_clk) begin
    if (gpuclk_rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= FILTER_LEN'({scl_hist, scl_sync[1]});
      sda_hist <= FILTER_LEN'({sda_hist, sda_sync[1]});
      if (&scl_hist) scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist) sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte  = {shreg[6:0], sda_f};

  always_ff @(posedge pixel_clk) begin
    if (gpuclk_rst) state <= S_IDLE;
    else            state <= state_next;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = S_IDLE;
    end else if (start) begin
      state_next = S_DEVADDR;
    end else begin
      case (state)
        S_DEVADDR:
          if (scl_rise && bit_cnt == 3'd7)
            state_next = (rx_byte[7:1] == DEV_ADDR) ? S_ACK : S_IGNORE;
        S_PTR, S_WDATA:
          if (scl_rise && bit_cnt == 3'd7) state_next = S_ACK;
        S_ACK:
          if (scl_fall && phase) state_next = ack_next;
        S_RDATA:
          if (scl_rise && bit_cnt == 3'd7) state_next = S_RACK;
        S_RACK:
          if (scl_rise && sda_f && !phase) state_next = S_IGNORE;
          else if (scl_fall && phase)      state_next = S_RDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    dbg_data = regs[dbg_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pixel_clk) begin
    if (gpuclk_rst) begin
      // NOTE: the register file is reset explicitly because its reset contents are architecturally visible.
      for (int i = 0; i < 256; i++) regs[i] <= REG_RESET;
      ptr          <= 8'h00;
      shreg        <= 8'h00;
      bit_cnt      <= 3'd0;
      phase        <= 1'b0;
      ack_next     <= S_PTR;
      sda_pull_low <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_addr      <= 8'h00;
      wr_data      <= 8'h00;
      nack_count   <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (start || stop) begin
        sda_pull_low <= 1'b0;
        bit_cnt      <= 3'd0;
        phase        <= 1'b0;
      end else begin
        case (state)
          S_DEVADDR:
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              phase   <= 1'b0;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == DEV_ADDR) ack_next <= rx_byte[0] ? S_RDATA : S_PTR;
                else if (nack_count != 8'hFF) nack_count <= nack_count + 8'd1;
              end
            end
          S_PTR:
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              phase   <= 1'b0;
              if (bit_cnt == 3'd7) begin
                ptr      <= rx_byte;
                ack_next <= S_WDATA;
              end
            end
          S_WDATA:
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              phase   <= 1'b0;
              if (bit_cnt == 3'd7) begin
                regs[ptr] <= rx_byte;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + 8'd1;
                ack_next  <= S_WDATA;
              end
            end
          S_ACK:
            if (scl_fall) begin
              if (!phase) begin
                sda_pull_low <= 1'b1;
                phase        <= 1'b1;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                if (ack_next == S_RDATA) begin
                  shreg        <= regs[ptr];
                  sda_pull_low <= ~regs[ptr][7];
                end else begin
                  sda_pull_low <= 1'b0;
                end
              end
            end
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr   <= ptr + 8'd1;
                phase <= 1'b0;
              end
            end
            if (scl_fall) begin
              sda_pull_low <= ~shreg[6];
              shreg        <= {shreg[6:0], 1'b0};
            end
          end
          S_RACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_pull_low <= 1'b0;
              end else begin
                shreg        <= regs[ptr];
                sda_pull_low <= ~regs[ptr][7];
                bit_cnt      <= 3'd0;
                phase        <= 1'b0;
              end
            end
            if (scl_rise && !sda_f) phase <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
